// File: rtl/multicycle_control_unit_if.sv
// Control-unit bus: instruction/status inputs from the datapath and every
// datapath enable/select driven back by the control FSM.
// Handshake: MemReady is a level from memory meaning "the access presented by
// the current strobes completes at the next rising CLK edge". The control unit
// holds MemRead/MemWrite/IorD steady until it sees MemReady=1, then moves on.
interface multicycle_control_unit_if #(
   parameter int INSTR_W = 16
);
   logic [INSTR_W-1:0] Instr;
   logic               Zero;
   logic               MemReady;

   logic               IRWrite;
   logic               PCWrite;
   logic               IorD;
   logic               MemRead;
   logic               MemWrite;
   logic               RegWrite;
   logic [1:0]         RegDst;
   logic [1:0]         MemtoReg;
   logic               ALUSrcA;
   logic [1:0]         ALUSrcB;
   logic [2:0]         ALUOp;
   logic [1:0]         PCSource;
   logic [3:0]         State;
   logic               Illegal;
   logic               Halted;
   logic               MemTimeout;

   // Datapath side: supplies instruction and status, consumes controls.
   modport master (
      output Instr, Zero, MemReady,
      input  IRWrite, PCWrite, IorD, MemRead, MemWrite, RegWrite, RegDst,
             MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource, State, Illegal,
             Halted, MemTimeout
   );

   // Control-unit side.
   modport slave (
      input  Instr, Zero, MemReady,
      output IRWrite, PCWrite, IorD, MemRead, MemWrite, RegWrite, RegDst,
             MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource, State, Illegal,
             Halted, MemTimeout
   );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM. Decodes Instr[15:12] and sequences fetch, decode,
// execute, memory and writeback. Memory states wait on MemReady, guarded by
// a watchdog that halts the machine if memory never answers.
module multicycle_control_unit #(
   parameter int INSTR_W    = 16,
   parameter int WAIT_LIMIT = 15
) (
   input  logic                          CLK,
   input  logic                          Reset,
   multicycle_control_unit_if.slave      bus
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      EXEC_R = 4'd2,
      EXEC_I = 4'd3,
      ADDR   = 4'd4,
      MEM_RD = 4'd5,
      MEM_WB = 4'd6,
      MEM_WR = 4'd7,
      ALU_WB = 4'd8,
      BRANCH = 4'd9,
      JUMP   = 4'd10,
      HALT   = 4'd11
   } state_t;

   // Last waiting cycle before the watchdog fires.
   localparam logic [3:0] WAIT_LAST = 4'(WAIT_LIMIT - 1);

   state_t     state;
   state_t     nextState;
   logic [3:0] waitCnt;
   logic       memTimeoutQ;

   logic [3:0] opcode;
   logic       memState;
   logic       waiting;
   logic       expire;
   logic       unusedInstrBits;

   assign opcode          = bus.Instr[INSTR_W-1 -: 4];
   assign unusedInstrBits = ^bus.Instr[INSTR_W-5:0];

   // A memory-facing state stalls while memory has not answered.
   assign memState = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
   assign waiting  = memState && !bus.MemReady;
   // MemReady arriving on the last allowed cycle wins, since waiting is then 0.
   assign expire   = waiting && (waitCnt == WAIT_LAST);

   // State register, watchdog counter and sticky timeout flag.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state       <= FETCH;
         waitCnt     <= 4'd0;
         memTimeoutQ <= 1'b0;
      end else begin
         state <= nextState;
         if (waiting && !expire) begin
            waitCnt <= waitCnt + 4'd1;
         end else begin
            waitCnt <= 4'd0;
         end
         if (expire) begin
            memTimeoutQ <= 1'b1;
         end
      end
   end

   // Next-state decode; a watchdog expiry diverts any memory wait to HALT.
   always_comb begin
      nextState = state;
      case (state)
         FETCH: begin
            if (bus.MemReady)  nextState = DECODE;
            else if (expire)   nextState = HALT;
         end
         DECODE: begin
            case (opcode)
               4'h0, 4'h1, 4'h2, 4'h3: nextState = EXEC_R;
               4'h4, 4'hC:             nextState = EXEC_I;
               4'h5, 4'h6:             nextState = ADDR;
               4'h7, 4'h8:             nextState = BRANCH;
               4'h9, 4'hA, 4'hB:       nextState = JUMP;
               4'hF:                   nextState = HALT;
               default:                nextState = FETCH;
            endcase
         end
         EXEC_R: nextState = ALU_WB;
         EXEC_I: nextState = ALU_WB;
         ALU_WB: nextState = FETCH;
         ADDR:   nextState = (opcode == 4'h5) ? MEM_RD : MEM_WR;
         MEM_RD: begin
            if (bus.MemReady)  nextState = MEM_WB;
            else if (expire)   nextState = HALT;
         end
         MEM_WB: nextState = FETCH;
         MEM_WR: begin
            if (bus.MemReady)  nextState = FETCH;
            else if (expire)   nextState = HALT;
         end
         BRANCH: nextState = FETCH;
         JUMP:   nextState = FETCH;
         HALT:   nextState = HALT;
         default: nextState = FETCH;
      endcase
   end

   // Datapath controls from the current state; all forced low during Reset
   // so an aborted instruction can never complete a write.
   always_comb begin
      bus.IRWrite  = 1'b0;
      bus.PCWrite  = 1'b0;
      bus.IorD     = 1'b0;
      bus.MemRead  = 1'b0;
      bus.MemWrite = 1'b0;
      bus.RegWrite = 1'b0;
      bus.RegDst   = 2'b00;
      bus.MemtoReg = 2'b00;
      bus.ALUSrcA  = 1'b0;
      bus.ALUSrcB  = 2'b00;
      bus.ALUOp    = 3'b000;
      bus.PCSource = 2'b00;
      bus.Illegal  = 1'b0;
      bus.Halted   = 1'b0;
      if (!Reset) begin
         case (state)
            FETCH: begin
               // PC+2 is computed alongside the read; both commit on MemReady.
               bus.MemRead = 1'b1;
               bus.ALUSrcB = 2'b01;
               bus.IRWrite = bus.MemReady;
               bus.PCWrite = bus.MemReady;
            end
            DECODE: begin
               // Branch target precomputed into ALUOut.
               bus.ALUSrcB = 2'b11;
               case (opcode)
                  4'hD, 4'hE: bus.Illegal = 1'b1;
                  default:    bus.Illegal = 1'b0;
               endcase
            end
            EXEC_R: begin
               bus.ALUSrcA = 1'b1;
               bus.ALUOp   = {1'b0, opcode[1:0]};
            end
            EXEC_I: begin
               bus.ALUSrcA = 1'b1;
               bus.ALUSrcB = 2'b10;
               bus.ALUOp   = (opcode == 4'hC) ? 3'b100 : 3'b000;
            end
            ALU_WB: begin
               bus.RegWrite = 1'b1;
               bus.RegDst   = (opcode[3:2] == 2'b00) ? 2'b01 : 2'b00;
            end
            ADDR: begin
               bus.ALUSrcA = 1'b1;
               bus.ALUSrcB = 2'b10;
            end
            MEM_RD: begin
               bus.MemRead = 1'b1;
               bus.IorD    = 1'b1;
            end
            MEM_WB: begin
               bus.RegWrite = 1'b1;
               bus.MemtoReg = 2'b01;
            end
            MEM_WR: begin
               bus.MemWrite = 1'b1;
               bus.IorD     = 1'b1;
            end
            BRANCH: begin
               bus.ALUSrcA  = 1'b1;
               bus.ALUOp    = 3'b001;
               bus.PCSource = 2'b01;
               bus.PCWrite  = ((opcode == 4'h7) &&  bus.Zero) ||
                              ((opcode == 4'h8) && !bus.Zero);
            end
            JUMP: begin
               bus.PCWrite  = 1'b1;
               bus.PCSource = (opcode == 4'hB) ? 2'b11 : 2'b10;
               if (opcode == 4'hA) begin
                  // jal links the already-incremented PC.
                  bus.RegWrite = 1'b1;
                  bus.RegDst   = 2'b10;
                  bus.MemtoReg = 2'b10;
               end
            end
            HALT: bus.Halted = 1'b1;
            default: ;
         endcase
      end
   end

   assign bus.State      = state;
   assign bus.MemTimeout = memTimeoutQ;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: per-instruction expected traces built
// from the instruction set description, replayed cycle by cycle.
module tb_multicycle_control_unit;

   localparam int INSTR_W    = 16;
   localparam int WAIT_LIMIT = 15;

   typedef struct packed {
      logic       irWrite;
      logic       pcWrite;
      logic       iorD;
      logic       memRead;
      logic       memWrite;
      logic       regWrite;
      logic [1:0] regDst;
      logic [1:0] memtoReg;
      logic       aluSrcA;
      logic [1:0] aluSrcB;
      logic [2:0] aluOp;
      logic [1:0] pcSource;
      logic       illegal;
      logic       halted;
      logic       memTimeout;
   } ctl_t;

   // Phase numbers as published for the State debug port.
   localparam logic [3:0] P_FETCH = 4'd0, P_DECODE = 4'd1, P_EXEC_R = 4'd2,
                          P_EXEC_I = 4'd3, P_ADDR = 4'd4, P_MEM_RD = 4'd5,
                          P_MEM_WB = 4'd6, P_MEM_WR = 4'd7, P_ALU_WB = 4'd8,
                          P_BRANCH = 4'd9, P_JUMP = 4'd10, P_HALT = 4'd11;

   // ---------------- clock / reset ----------------
   logic CLK   = 1'b0;
   logic Reset = 1'b0;
   always #5 CLK = ~CLK;

   multicycle_control_unit_if #(.INSTR_W(INSTR_W)) bus ();

   multicycle_control_unit #(
      .INSTR_W   (INSTR_W),
      .WAIT_LIMIT(WAIT_LIMIT)
   ) dut (
      .CLK  (CLK),
      .Reset(Reset),
      .bus  (bus)
   );

   // ---------------- scoreboard ----------------
   int          checkCnt = 0;
   int          passCnt  = 0;
   logic [24:0] expQ[$];
   logic        rdyQ[$];
   logic        modelTo     = 1'b0;
   logic        modelHalted = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCnt++;
      if (got === exp) passCnt++;
      else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
   endtask

   function automatic ctl_t observed();
      ctl_t c;
      c.irWrite    = bus.IRWrite;
      c.pcWrite    = bus.PCWrite;
      c.iorD       = bus.IorD;
      c.memRead    = bus.MemRead;
      c.memWrite   = bus.MemWrite;
      c.regWrite   = bus.RegWrite;
      c.regDst     = bus.RegDst;
      c.memtoReg   = bus.MemtoReg;
      c.aluSrcA    = bus.ALUSrcA;
      c.aluSrcB    = bus.ALUSrcB;
      c.aluOp      = bus.ALUOp;
      c.pcSource   = bus.PCSource;
      c.illegal    = bus.Illegal;
      c.halted     = bus.Halted;
      c.memTimeout = bus.MemTimeout;
      return c;
   endfunction

   // ---------------- reference model ----------------
   task automatic push(input logic rdy, input logic [3:0] ph, input ctl_t c);
      c.memTimeout = modelTo;
      c.halted     = (ph == P_HALT);
      rdyQ.push_back(rdy);
      expQ.push_back({ph, c});
   endtask

   task automatic pushHalt(input int n);
      ctl_t z = '0;
      modelHalted = 1'b1;
      for (int i = 0; i < n; i++) push(1'($urandom_range(0, 1)), P_HALT, z);
   endtask

   // Memory access: 'waits' cycles without MemReady, then the acknowledge
   // cycle. The WAIT_LIMIT-th consecutive unanswered cycle ends in timeout.
   task automatic memPhase(input logic [3:0] ph, input ctl_t c, input ctl_t ack,
                           input int waits, output logic ok);
      ok = 1'b1;
      for (int k = 0; k < waits; k++) begin
         push(1'b0, ph, c);
         if (k == WAIT_LIMIT - 1) begin
            modelTo = 1'b1;
            ok      = 1'b0;
            pushHalt(3);
            return;
         end
      end
      push(1'b1, ph, ack);
   endtask

   task automatic planInstr(input logic [15:0] ins, input logic z, input int fw, input int mw);
      logic [3:0] op = ins[15:12];
      ctl_t c, a;
      logic ok;
      modelHalted = 1'b0;
      // fetch: read at PC, PC+2 on the ALU
      c = '0; c.memRead = 1'b1; c.aluSrcB = 2'b01;
      a = c;  a.irWrite = 1'b1; a.pcWrite = 1'b1;
      memPhase(P_FETCH, c, a, fw, ok);
      if (!ok) return;
      // decode: branch target PC + (imm<<1)
      c = '0; c.aluSrcB = 2'b11; c.illegal = (op == 4'hD || op == 4'hE);
      push(1'b1, P_DECODE, c);
      if (c.illegal) return;
      if (op <= 4'h3) begin
         c = '0; c.aluSrcA = 1'b1; c.aluOp = {1'b0, op[1:0]};
         push(1'b1, P_EXEC_R, c);
         c = '0; c.regWrite = 1'b1; c.regDst = 2'b01;
         push(1'b1, P_ALU_WB, c);
      end else if (op == 4'h4 || op == 4'hC) begin
         c = '0; c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; c.aluOp = (op == 4'hC) ? 3'd4 : 3'd0;
         push(1'b1, P_EXEC_I, c);
         c = '0; c.regWrite = 1'b1;
         push(1'b1, P_ALU_WB, c);
      end else if (op == 4'h5 || op == 4'h6) begin
         c = '0; c.aluSrcA = 1'b1; c.aluSrcB = 2'b10;
         push(1'b1, P_ADDR, c);
         c = '0; c.iorD = 1'b1;
         if (op == 4'h5) c.memRead = 1'b1; else c.memWrite = 1'b1;
         memPhase((op == 4'h5) ? P_MEM_RD : P_MEM_WR, c, c, mw, ok);
         if (!ok) return;
         if (op == 4'h5) begin
            c = '0; c.regWrite = 1'b1; c.memtoReg = 2'b01;
            push(1'b1, P_MEM_WB, c);
         end
      end else if (op == 4'h7 || op == 4'h8) begin
         c = '0; c.aluSrcA = 1'b1; c.aluOp = 3'd1; c.pcSource = 2'b01;
         c.pcWrite = (op == 4'h7) ? z : !z;
         push(1'b1, P_BRANCH, c);
      end else if (op >= 4'h9 && op <= 4'hB) begin
         c = '0; c.pcWrite = 1'b1; c.pcSource = (op == 4'hB) ? 2'b11 : 2'b10;
         if (op == 4'hA) begin
            c.regWrite = 1'b1; c.regDst = 2'b10; c.memtoReg = 2'b10;
         end
         push(1'b1, P_JUMP, c);
      end else begin
         pushHalt(3);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Called at posedge+1; replays up to maxN planned cycles (all if < 0).
   task automatic runPlan(input string name, input int maxN);
      int n = expQ.size();
      if (maxN >= 0 && maxN < n) n = maxN;
      for (int i = 0; i < n; i++) begin
         bus.MemReady = rdyQ[i];
         @(negedge CLK);
         check($sformatf("%s#%0d.state", name, i), 32'(bus.State), 32'(expQ[i][24:21]));
         check($sformatf("%s#%0d.ctl", name, i), 32'(observed()), 32'(expQ[i][20:0]));
         @(posedge CLK);
         #1;
      end
      expQ.delete();
      rdyQ.delete();
   endtask

   task automatic doInstr(input string name, input logic [15:0] ins, input logic z,
                          input int fw, input int mw, input int maxN);
      bus.Instr = ins;
      bus.Zero  = z;
      planInstr(ins, z, fw, mw);
      runPlan(name, maxN);
   endtask

   task automatic doReset();
      Reset        = 1'b1;
      bus.MemReady = 1'b1;
      #1;
      check("rst.state", 32'(bus.State), 32'(P_FETCH));
      check("rst.ctl", 32'(observed()), 32'(ctl_t'('0)));
      @(posedge CLK);
      #1;
      Reset       = 1'b0;
      modelTo     = 1'b0;
      modelHalted = 1'b0;
   endtask

   function automatic int pickWait();
      int r = $urandom_range(0, 19);
      if (r == 0) return WAIT_LIMIT;
      if (r == 1) return WAIT_LIMIT - 1;
      return $urandom_range(0, 2);
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      bus.Instr    = '0;
      bus.Zero     = 1'b0;
      bus.MemReady = 1'b0;
      #2;
      doReset();

      doInstr("sub",   16'h1234, 1'b0, 0, 0, -1);
      doInstr("lw",    16'h5123, 1'b0, 0, 3, -1);
      doInstr("beqT",  16'h7005, 1'b1, 0, 0, -1);
      doInstr("beqF",  16'h7005, 1'b0, 0, 0, -1);
      doInstr("bneT",  16'h8005, 1'b1, 0, 0, -1);
      doInstr("bneF",  16'h8005, 1'b0, 0, 0, -1);
      doInstr("jal",   16'hA010, 1'b0, 0, 0, -1);
      doInstr("j",     16'h9123, 1'b0, 1, 0, -1);
      doInstr("jr",    16'hB040, 1'b0, 0, 0, -1);
      doInstr("illD",  16'hD000, 1'b0, 0, 0, -1);
      doInstr("illE",  16'hE7FF, 1'b0, 0, 0, -1);
      doInstr("addi",  16'h4321, 1'b0, 2, 0, -1);
      doInstr("lui",   16'hC0FF, 1'b0, 0, 0, -1);
      doInstr("swEdge", 16'h6abc, 1'b0, 0, WAIT_LIMIT - 1, -1);
      doInstr("fEdge", 16'h2001, 1'b0, WAIT_LIMIT - 1, 0, -1);
      doInstr("fTo",   16'h0000, 1'b0, WAIT_LIMIT, 0, -1);
      doReset();
      doInstr("lwTo",  16'h5000, 1'b0, 0, WAIT_LIMIT + 3, -1);
      doReset();
      doInstr("halt",  16'hF000, 1'b0, 0, 0, -1);
      doReset();
      // Abort a store mid-wait: fetch, decode, addr, then three MEM_WR cycles.
      doInstr("swAbort", 16'h6000, 1'b0, 0, 10, 6);
      doReset();

      for (int t = 0; t < 60; t++) begin
         logic [15:0] ins;
         ins = 16'($urandom);
         doInstr($sformatf("rnd%0d", t), ins, 1'($urandom_range(0, 1)), pickWait(), pickWait(), -1);
         if (modelHalted) doReset();
      end

      // ---------------- final report ----------------
      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multicycle control FSM directly downstream of the 16-bit instruction register.
- Decodes the latched instruction's opcode field, Instr[15:12], and sequences the datapath through fetch, decode, execute, memory and writeback.
- Drives every datapath enable, including IRWrite, which feeds the instruction register's RegWrite input.
- Handles variable-latency memory through a MemReady handshake with a timeout watchdog.

Parameters:
- INSTR_W, 16, instruction width; opcode is always Instr[INSTR_W-1:INSTR_W-4].
- WAIT_LIMIT, 15, maximum cycles a memory state waits for MemReady before timeout.

Ports:
- CLK, input, 1, system clock, rising edge.
- Reset, input, 1, asynchronous, active-high.
- Instr, input, INSTR_W, instruction register DataOut.
- Zero, input, 1, ALU zero flag.
- MemReady, input, 1, memory access completes this cycle.
- IRWrite, output, 1, instruction register load enable.
- PCWrite, output, 1, PC load enable.
- IorD, output, 1, memory address select: 0 = PC, 1 = ALUOut.
- MemRead, output, 1, memory read strobe.
- MemWrite, output, 1, memory write strobe.
- RegWrite, output, 1, register file write enable.
- RegDst, output, 2, destination register select: 00 = rt, 01 = rd, 10 = link.
- MemtoReg, output, 2, writeback source: 00 = ALUOut, 01 = MDR, 10 = PC.
- ALUSrcA, output, 1, ALU A input: 0 = PC, 1 = regA.
- ALUSrcB, output, 2, ALU B input: 00 = regB, 01 = const 2, 10 = sext imm, 11 = sext imm<<1.
- ALUOp, output, 3, ALU operation: 000 add, 001 sub, 010 and, 011 or, 100 lui.
- PCSource, output, 2, PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = regA.
- State, output, 4, current state (debug).
- Illegal, output, 1, one-cycle pulse on undefined opcode.
- Halted, output, 1, high while in HALT.
- MemTimeout, output, 1, sticky; set on watchdog expiry.

Behaviour:
- Opcodes: 0 add, 1 sub, 2 and, 3 or, 4 addi, 5 lw, 6 sw, 7 beq, 8 bne, 9 j, A jal, B jr, C lui, F halt. D and E are illegal.
- State encoding: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, ADDR=4, MEM_RD=5, MEM_WB=6, MEM_WR=7, ALU_WB=8, BRANCH=9, JUMP=10, HALT=11.
- Reset:
  - State=FETCH.
  - All enables and strobes (IRWrite, PCWrite, MemRead, MemWrite, RegWrite) forced 0 while Reset is high.
  - All select buses 0; Illegal=0, Halted=0, MemTimeout=0; wait counter=0.
  - Reset asserted mid-instruction aborts it immediately; no partial write occurs.
- Outputs are combinational from State. Exceptions: PCWrite and IRWrite in FETCH, and PCWrite in BRANCH, also depend on the inputs noted below. Any output not listed for a state is 0.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=add, PCSource=00.
  - IRWrite=PCWrite=MemReady.
  - Go to DECODE when MemReady; otherwise stay.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALUOp=add (precomputes branch target).
  - Next state: 0–3 → EXEC_R; 4, C → EXEC_I; 5, 6 → ADDR; 7, 8 → BRANCH; 9, A, B → JUMP; F → HALT.
  - Illegal opcode: Illegal=1 for this cycle, next state FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=Instr[13:12] (add/sub/and/or) → ALU_WB.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=add (addi) or lui (C) → ALU_WB.
- ALU_WB:
  - RegWrite=1, MemtoReg=00.
  - RegDst=01 for R-type, 00 for I-type.
  - → FETCH.
- ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=add → MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: MemRead=1, IorD=1; → MEM_WB when MemReady, else stay.
- MEM_WB: RegWrite=1, MemtoReg=01, RegDst=00 → FETCH.
- MEM_WR: MemWrite=1, IorD=1; → FETCH when MemReady, else stay.
- BRANCH:
  - ALUSrcA=1, ALUSrcB=00, ALUOp=sub, PCSource=01.
  - PCWrite=(op 7 & Zero) | (op 8 & ~Zero).
  - → FETCH.
- JUMP:
  - PCWrite=1; PCSource=10 for j/jal, 11 for jr.
  - jal additionally: RegWrite=1, RegDst=10, MemtoReg=10 (PC already incremented).
  - → FETCH.
- HALT: Halted=1, all enables 0; remains until Reset.
- Latency without wait states: R/I ALU 4, lw 5, sw 4, branch 3, jump 3 cycles.
- Watchdog:
  - 4-bit wait counter increments each cycle spent in FETCH, MEM_RD or MEM_WR with MemReady=0; clears on leaving those states.
  - When the counter reaches WAIT_LIMIT with MemReady still 0: MemTimeout←1, next state HALT, no writes issued.
  - MemReady=1 in the same cycle as the limit is reached wins: normal transition, no timeout.
- Instr is sampled only in DECODE and later states. IRWrite is 0 outside FETCH, so Instr is stable through execution.

Test Plan:
- Reset mid-MEM_WR: assert Reset with MemWrite=1 → MemWrite drops to 0 within the same cycle; after release, State=0, IRWrite follows MemReady.
- Instr=0x1234 (sub), MemReady=1 → states 0,1,2,8,0; EXEC_R ALUOp=001; ALU_WB RegWrite=1, RegDst=01.
- Instr=0x5123 (lw) with MemReady=0 for 3 cycles in MEM_RD → 3 extra MEM_RD cycles, then MEM_WB with MemtoReg=01, RegWrite=1; total 8 cycles.
- Instr=0x7005 (beq): Zero=1 → PCWrite=1, PCSource=01 in BRANCH; repeat with Zero=0 → PCWrite=0. Instr=0x8005 (bne) gives the inverse.
- Instr=0xA010 (jal) → JUMP state: PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10. Instr=0xD000 → Illegal pulses in DECODE, then FETCH.
- MemReady held 0 in FETCH → after 15 cycles MemTimeout=1, Halted=1, State=11; stays until Reset. Instr=0xF000 → HALT with MemTimeout=0.
